// File: rtl/cache_arbiter_pkg.sv
// Shared types and default widths for the I/D cache memory-port arbiter.
package cache_arbiter_pkg;

  localparam int unsigned DEFAULT_ADDR_W = 32;
  localparam int unsigned DEFAULT_LINE_W = 256;

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} arb_state_t;

  typedef enum logic {REQ_I, REQ_D} requester_t;

endpackage

// File: rtl/cache_arbiter.sv
// Shares one physical-memory line port between the I-cache and D-cache,
// granting one latched command at a time with round-robin on contention.
module cache_arbiter
  import cache_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
  parameter int unsigned LINE_W = DEFAULT_LINE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  arb_state_t        state, state_next;
  requester_t        last_grant, last_grant_next;
  logic [ADDR_W-1:0] cmd_addr, cmd_addr_next;
  logic [LINE_W-1:0] cmd_wdata, cmd_wdata_next;
  logic              cmd_write, cmd_write_next;
  logic              pend_i, pend_d, pick_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= REQ_I;
      cmd_addr   <= '0;
      cmd_wdata  <= '0;
      cmd_write  <= 1'b0;
    end else begin
      state      <= state_next;
      last_grant <= last_grant_next;
      cmd_addr   <= cmd_addr_next;
      cmd_wdata  <= cmd_wdata_next;
      cmd_write  <= cmd_write_next;
    end
  end

  assign pend_i = i_read;
  assign pend_d = d_read | d_write;
  // On contention the requester that did not win last time goes first.
  assign pick_d = pend_d & (~pend_i | (last_grant == REQ_I));

  always_comb begin
    state_next      = state;
    last_grant_next = last_grant;
    cmd_addr_next   = cmd_addr;
    cmd_wdata_next  = cmd_wdata;
    cmd_write_next  = cmd_write;
    pmem_read       = 1'b0;
    pmem_write      = 1'b0;
    pmem_address    = cmd_addr;
    pmem_wdata      = cmd_wdata;
    i_resp          = 1'b0;
    d_resp          = 1'b0;
    unique case (state)
      IDLE: begin
        if (pend_i | pend_d) begin
          state_next      = pick_d ? SERVE_D : SERVE_I;
          last_grant_next = pick_d ? REQ_D : REQ_I;
          cmd_addr_next   = pick_d ? d_address : i_address;
          cmd_wdata_next  = pick_d ? d_wdata : '0;
          // A simultaneous read+write from the D-cache resolves to the writeback.
          cmd_write_next  = pick_d & d_write;
        end
      end
      SERVE_I, SERVE_D: begin
        pmem_read  = ~cmd_write;
        pmem_write = cmd_write;
        if (pmem_resp) begin
          state_next = IDLE;
          i_resp     = (state == SERVE_I);
          d_resp     = (state == SERVE_D);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Randomized bench for cache_arbiter: transaction-level arbitration model feeding
// scoreboards that a negedge monitor drains against the DUT.
module tb_cache_arbiter;

  localparam int NCYC = 2000;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         i_read = 1'b0, d_read = 1'b0, d_write = 1'b0, pmem_resp = 1'b0;
  logic [31:0]  i_address = '0, d_address = '0;
  logic [255:0] d_wdata = '0, pmem_rdata = '0;
  logic [255:0] i_rdata, d_rdata, pmem_wdata;
  logic         i_resp, d_resp, pmem_read, pmem_write;
  logic [31:0]  pmem_address;

  cache_arbiter dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         write;
    logic [31:0]  addr;
    logic [255:0] wdata;
  } txn_t;

  typedef struct {
    logic         who;  // 0 = I-cache, 1 = D-cache
    logic [255:0] rdata;
  } resp_t;

  txn_t  txn_q[$];
  resp_t resp_q[$];
  int    total = 0;
  int    bad = 0;

  function automatic void chk(string name, logic [255:0] act, logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // Reference model: one transaction at a time, the idle winner is the sole
  // requester or, if both want the port, whoever did not win last time.
  bit   m_busy, m_owner, m_last, m_write, m_pi, m_pd, m_who;
  txn_t m_t;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_owner = 0; m_last = 0; m_write = 0;
      txn_q.delete();
      resp_q.delete();
    end else if (m_busy) begin
      if (pmem_resp) m_busy = 0;
    end else begin
      m_pi = i_read;
      m_pd = d_read | d_write;
      if (m_pi || m_pd) begin
        m_who     = (m_pi && m_pd) ? !m_last : m_pd;
        m_t.write = m_who && d_write;
        m_t.addr  = m_who ? d_address : i_address;
        m_t.wdata = d_wdata;
        txn_q.push_back(m_t);
        m_busy  = 1;
        m_owner = m_who;
        m_last  = m_who;
        m_write = m_t.write;
      end
    end
  end

  // Monitor
  bit    have_cur, i_seen, d_seen;
  txn_t  cur;
  resp_t er;

  always @(negedge clk) begin
    if (rst) begin
      have_cur = 0; i_seen = 0; d_seen = 0;
      chk("reset_outputs", 256'({pmem_read, pmem_write, i_resp, d_resp}), 256'(0));
    end else begin
      i_seen = i_resp;
      d_seen = d_resp;
      chk("strobe_timing", 256'(pmem_read | pmem_write), 256'(m_busy));
      if ((pmem_read | pmem_write) && !have_cur) begin
        chk("txn_expected", 256'(txn_q.size() != 0), 256'(1));
        if (txn_q.size() != 0) begin
          cur = txn_q.pop_front();
          have_cur = 1;
        end
      end
      if (have_cur) begin
        chk("cmd", 256'({pmem_write, pmem_read, pmem_address}),
            256'({cur.write, ~cur.write, cur.addr}));
        if (cur.write) chk("wdata", pmem_wdata, cur.wdata);
      end
      if (resp_q.size() != 0) begin
        er = resp_q.pop_front();
        chk("resp_who", 256'({i_resp, d_resp}), 256'(er.who ? 2'b01 : 2'b10));
        chk("resp_data", er.who ? d_rdata : i_rdata, er.rdata);
        have_cur = 0;
      end else begin
        chk("no_stray_resp", 256'({i_resp, d_resp}), 256'(0));
      end
    end
  end

  // Stimulus: two requester agents and a memory responder
  bit i_out, d_out, run, armed, did_reset;
  int delay;
  int kind;

  initial begin
    #1 rst = 1'b1;
    #1;
    chk("reset_strobes", 256'({pmem_read, pmem_write, i_resp, d_resp}), 256'(0));
    chk("reset_address", 256'(pmem_address), 256'(0));
    chk("reset_wdata", pmem_wdata, 256'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    // Both caches ask at once straight out of reset.
    i_read = 1; i_out = 1; i_address = {1'b0, 26'($urandom), 5'b0};
    d_read = 1; d_out = 1; d_address = {1'b1, 26'($urandom), 5'b0}; d_wdata = rand256();

    for (int cyc = 0; cyc < NCYC + 100; cyc++) begin
      @(posedge clk);
      #1;
      run = (cyc < NCYC);
      if (!did_reset && cyc >= 800 && m_busy && m_owner && m_write) begin
        did_reset = 1;
        pmem_resp = 0;
        armed = 0;
        #2;
        chk("pre_reset_write", 256'(pmem_write), 256'(1));
        rst = 1'b1;
        #1;
        chk("reset_kills_strobes", 256'({pmem_read, pmem_write, i_resp, d_resp}), 256'(0));
        i_read = 0; d_read = 0; d_write = 0; i_out = 0; d_out = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        i_read = 1; i_out = 1; i_address = {1'b0, 26'($urandom), 5'b0};
      end else begin
        if (i_seen) begin
          i_read = 0; i_out = 0;
        end else if (!i_out && run && $urandom_range(0, 2) != 0) begin
          i_read = 1; i_out = 1; i_address = {1'b0, 26'($urandom), 5'b0};
        end else if (i_out && i_read && m_busy && !m_owner && $urandom_range(0, 3) == 0) begin
          i_read = 0;
        end

        if (d_seen) begin
          d_read = 0; d_write = 0; d_out = 0;
        end else if (!d_out && run && $urandom_range(0, 2) != 0) begin
          kind = int'($urandom_range(0, 7));
          d_write = (kind <= 3);
          d_read  = (kind == 0) || (kind > 3);
          d_out = 1;
          d_address = {1'b1, 26'($urandom), 5'b0};
          d_wdata = rand256();
        end else if (d_out && (d_read || d_write) && m_busy && m_owner &&
                     $urandom_range(0, 3) == 0) begin
          d_read = 0; d_write = 0;
        end

        pmem_resp = 0;
        pmem_rdata = rand256();
        if (m_busy) begin
          if (!armed) begin
            armed = 1;
            delay = int'($urandom_range(0, 4));
          end
          if (delay == 0) begin
            pmem_resp = 1;
            resp_q.push_back('{who: m_owner, rdata: pmem_rdata});
            armed = 0;
          end else begin
            delay--;
          end
        end else if ($urandom_range(0, 5) == 0) begin
          pmem_resp = 1;  // stray response while idle must be ignored
        end
      end
    end

    chk("reset_exercised", 256'(did_reset), 256'(1));
    chk("drained", 256'({i_out, d_out, m_busy, have_cur, txn_q.size() != 0}), 256'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
